cc_ball_shifter: RTL

CC_BALL_SHIFTER -- requirements
Module: cc_ball_shifter

---
 rtl/cc_ball_shifter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/cc_ball_shifter.sv
// Pong ball position register: a one-hot ball bouncing across bits 3..0 of the bus.
// The FSM drives the ball, counts misses and exposes its state for observation.
module cc_ball_shifter #(
  parameter int BALLSHIFTER_DATAWIDTH = 8
) (
  input  logic                             CC_BALLSHIFTER_CLOCK_50,
  input  logic                             CC_BALLSHIFTER_RESET_InHigh,
  input  logic                             CC_BALLSHIFTER_tick_InHigh,
  input  logic                             CC_BALLSHIFTER_serve_InLow,
  input  logic                             CC_BALLSHIFTER_hit_InLow,
  input  logic                             CC_BALLSHIFTER_izquierda_InLow,
  input  logic                             CC_BALLSHIFTER_derecha_InLow,
  output logic [BALLSHIFTER_DATAWIDTH-1:0] CC_BALLSHIFTER_data_OutBUS,
  output logic                             CC_BALLSHIFTER_miss_OutHigh,
  output logic [3:0]                       CC_BALLSHIFTER_misscount_OutBUS,
  output logic [2:0]                       CC_BALLSHIFTER_state_OutBUS
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MOVE_RIGHT = 3'd1,
    MOVE_LEFT  = 3'd2,
    MISS       = 3'd3
  } ballState_t;

  localparam logic [BALLSHIFTER_DATAWIDTH-1:0] BALL_HOME  = BALLSHIFTER_DATAWIDTH'(4'b1000);
  localparam logic [BALLSHIFTER_DATAWIDTH-1:0] BALL_EMPTY = '0;
  localparam logic [BALLSHIFTER_DATAWIDTH-1:0] LANE_MASK  = BALLSHIFTER_DATAWIDTH'(4'b1111);

  ballState_t                       state;
  logic [BALLSHIFTER_DATAWIDTH-1:0] ballBus;
  logic [BALLSHIFTER_DATAWIDTH-1:0] ballRight;
  logic [BALLSHIFTER_DATAWIDTH-1:0] ballLeft;
  logic [3:0]                       laneBits;
  logic                             ballLegal;
  logic                             missPulse;
  logic [3:0]                       missCount;

  // Shifts are masked to the four-position lane, so a ball pushed off either end
  // becomes an empty bus and is caught by the legality check on the next edge.
  always_comb begin
    laneBits  = ballBus[3:0];
    ballRight = (ballBus >> 1) & LANE_MASK;
    ballLeft  = (ballBus << 1) & LANE_MASK;
    ballLegal = ((ballBus & ~LANE_MASK) == BALL_EMPTY) &&
                (laneBits != 4'b0000) &&
                ((laneBits & (laneBits - 4'd1)) == 4'b0000);
  end

  always_ff @(posedge CC_BALLSHIFTER_CLOCK_50) begin
    if (CC_BALLSHIFTER_RESET_InHigh) begin
      state     <= IDLE;
      ballBus   <= BALL_HOME;
      missPulse <= 1'b0;
      missCount <= 4'd0;
    end else begin
      missPulse <= 1'b0;
      case (state)
        IDLE: begin
          ballBus <= BALL_HOME;
          if (!CC_BALLSHIFTER_serve_InLow) state <= MOVE_RIGHT;
        end

        MOVE_RIGHT: begin
          if (!ballLegal) begin
            ballBus <= BALL_HOME;
            state   <= IDLE;
          end else if (CC_BALLSHIFTER_tick_InHigh) begin
            if (CC_BALLSHIFTER_derecha_InLow) begin
              ballBus <= ballRight;
            end else if (!CC_BALLSHIFTER_hit_InLow) begin
              ballBus <= ballLeft;
              state   <= MOVE_LEFT;
            end else begin
              ballBus   <= BALL_EMPTY;
              state     <= MISS;
              missPulse <= 1'b1;
              if (missCount != 4'd15) missCount <= missCount + 4'd1;
            end
          end
        end

        MOVE_LEFT: begin
          if (!ballLegal) begin
            ballBus <= BALL_HOME;
            state   <= IDLE;
          end else if (CC_BALLSHIFTER_tick_InHigh) begin
            // The far wall always returns the ball; no paddle involved.
            if (CC_BALLSHIFTER_izquierda_InLow) begin
              ballBus <= ballLeft;
            end else begin
              ballBus <= ballRight;
              state   <= MOVE_RIGHT;
            end
          end
        end

        MISS: begin
          if (!CC_BALLSHIFTER_serve_InLow) begin
            ballBus <= BALL_HOME;
            state   <= MOVE_RIGHT;
          end else begin
            ballBus <= BALL_EMPTY;
          end
        end

        default: begin
          ballBus <= BALL_HOME;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign CC_BALLSHIFTER_data_OutBUS      = ballBus;
  assign CC_BALLSHIFTER_miss_OutHigh     = missPulse;
  assign CC_BALLSHIFTER_misscount_OutBUS = missCount;
  assign CC_BALLSHIFTER_state_OutBUS     = state;

endmodule
